// File: rtl/board_io_pkg.sv
// board_io_pkg
// Purpose : Shared register map and defaults for the board I/O blocks (board_led, led_pwm).
// Contents: register address constants, duty defaults, PWM compare helper.
// Options : the PWM helper is only referenced when BOARD_LED_PWM_EN is defined.
package board_io_pkg;

    // Register map
    localparam logic [1:0] REG_PATTERN = 2'd0;
    localparam logic [1:0] REG_DUTY    = 2'd1;
    localparam logic [1:0] REG_BLINK   = 2'd2;

    // Full-scale duty forces the LEDs on continuously; it is also the reset value.
    localparam logic [7:0] DUTY_FULL    = 8'hFF;
    localparam logic [7:0] DUTY_DEFAULT = DUTY_FULL;

    // PWM level for one 8-bit counter value. A plain compare would leave
    // full scale dark for one clock in 256, so DUTY_FULL is forced on.
    function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/led_pwm.sv
// led_pwm
// Purpose : Free-running 8-bit PWM counter and duty compare for LED dimming.
// Ports   : clk    - clock, rising edge
//           reset  - synchronous active-high reset, clears the counter
//           duty   - on-time in counts out of 256 (255 = always on)
//           pwm_on - high while the LEDs may be lit
// Options : instantiated by board_led only when BOARD_LED_PWM_EN is defined.
module led_pwm
    import board_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] duty,
    output logic       pwm_on
);

    logic [7:0] pwm_cnt_q, pwm_cnt_d;

    // Wraps 255 -> 0 naturally.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm_on = pwm_level(pwm_cnt_q, duty);

endmodule

// File: rtl/board_led.sv
// board_led
// Purpose : Bus-programmable board LED driver with pattern, blink and optional PWM dimming.
// Ports   : clk           - clock, rising edge
//           reset         - synchronous active-high reset (wins over we)
//           addr          - register select: 0 PATTERN, 1 DUTY, 2 BLINK, 3 reserved
//           data_in       - write data
//           we            - write strobe, one write per high cycle
//           data          - registered readback of the register addressed last cycle
//           ext_board_led - registered LED drive, active-high
// Options : define BOARD_LED_PWM_EN to build the DUTY register and led_pwm dimmer;
//           otherwise the LEDs run at full brightness and addr 1 reads 0.
module board_led
    import board_io_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned LED_WIDTH      = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic        [1:0]            addr,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         we,
    output logic signed [DATA_WIDTH-1:0] data,
    output logic        [LED_WIDTH-1:0]  ext_board_led
);

    logic [LED_WIDTH-1:0]      pattern_q, pattern_d;
    logic [7:0]                blink_q, blink_d;
    logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
    logic [7:0]                blink_cnt_q, blink_cnt_d;
    logic                      phase_q, phase_d;
    logic [LED_WIDTH-1:0]      on_q, on_d;
    logic [LED_WIDTH-1:0]      led_q, led_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;

    logic wr_pattern, wr_blink;
    logic tick;
    logic pwm_on;

    assign wr_pattern = we && (addr == REG_PATTERN);
    assign wr_blink   = we && (addr == REG_BLINK);

    // Tick on the clock where the prescaler wraps from all-ones to zero.
    assign tick = (psc_q == {PRESCALE_WIDTH{1'b1}});

`ifdef BOARD_LED_PWM_EN
    logic [7:0] duty_q, duty_d;
    logic       wr_duty;

    assign wr_duty = we && (addr == REG_DUTY);

    always_comb begin
        duty_d = duty_q;
        if (wr_duty) begin
            duty_d = data_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q <= DUTY_DEFAULT;
        end else begin
            duty_q <= duty_d;
        end
    end

    led_pwm u_led_pwm (
        .clk    (clk),
        .reset  (reset),
        .duty   (duty_q),
        .pwm_on (pwm_on)
    );
`else
    assign pwm_on = 1'b1;
`endif

    // Register writes and prescaler
    always_comb begin
        pattern_d = pattern_q;
        blink_d   = blink_q;
        psc_d     = psc_q + 1'b1;
        if (wr_pattern) begin
            pattern_d = data_in[LED_WIDTH-1:0];
        end
        if (wr_blink) begin
            blink_d = data_in[7:0];
        end
    end

    // Blink half-period counter. A BLINK write restarts the half-period with
    // the LEDs on and beats a tick landing on the same clock.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (wr_blink || (blink_q == 8'd0)) begin
            blink_cnt_d = 8'd0;
            phase_d     = 1'b1;
        end else if (tick) begin
            // blink_cnt_q stays below blink_q, so the +1 cannot overflow.
            if (blink_cnt_q + 8'd1 == blink_q) begin
                blink_cnt_d = 8'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    // LED on term is staged once before the output flop, so a pattern
    // written at edge N drives the pins after edge N+2.
    always_comb begin
        on_d  = pattern_q & {LED_WIDTH{phase_q & pwm_on}};
        led_d = on_q;
    end

    // Readback, zero-extended
    always_comb begin
        data_d = '0;
        case (addr)
            REG_PATTERN: data_d = DATA_WIDTH'(pattern_q);
`ifdef BOARD_LED_PWM_EN
            REG_DUTY:    data_d = DATA_WIDTH'(duty_q);
`endif
            REG_BLINK:   data_d = DATA_WIDTH'(blink_q);
            default:     data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q   <= '0;
            blink_q     <= '0;
            psc_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            on_q        <= '0;
            led_q       <= '0;
            data_q      <= '0;
        end else begin
            pattern_q   <= pattern_d;
            blink_q     <= blink_d;
            psc_q       <= psc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            on_q        <= on_d;
            led_q       <= led_d;
            data_q      <= data_d;
        end
    end

    assign data          = data_q;
    assign ext_board_led = led_q;

endmodule
